// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit adder processing one 2-bit slice per clock, LSB first, start/busy/done handshake
module digit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] op_a, op_b, partial, partial_n;
  logic             carry, accept, last;
  logic [IW-1:0]    idx;
  logic [2:0]       slc;
  assign accept = start && state != RUN;
  assign last   = idx == IW'(N - 1);
  assign busy   = state == RUN;
  assign done   = state == DONE;
  always_comb begin
    slc = {1'b0, op_a[2*idx +: 2]} + {1'b0, op_b[2*idx +: 2]} + {2'b00, carry};
    partial_n = partial;
    partial_n[2*idx +: 2] = slc[1:0];
    state_n = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      partial <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      op_a    <= a;
      op_b    <= b;
      carry   <= cin;
      idx     <= '0;
      partial <= '0;
    end else if (state == RUN) begin
      partial <= partial_n;
      carry   <= slc[2];
      idx     <= last ? '0 : idx + 1'b1;
      if (last) begin
        sum  <= partial_n;
        cout <= slc[2];
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed scoreboard bench for 8-bit and 2-bit digit_serial_adder instances
module tb_digit_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start2 = 1'b0, cin2 = 1'b0, busy2, done2, cout2;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  logic [8:0] q8[$];
  logic [2:0] q2[$];
  int checks = 0, errors = 0;

  digit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  digit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop8_chk(input string tag);
    logic [8:0] e;
    chk({tag, "_sb_pending"}, 32'(q8.size() > 0), 32'd1);
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk(tag, {23'd0, cout8, sum8}, {23'd0, e});
    end
  endtask

  task automatic add8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    int n, nb;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(9'(a) + 9'(b) + 9'(c));
    @(negedge clk);
    start8 = 1'b0;
    n = 1; nb = 0;
    while (!done8 && n < 20) begin
      if (busy8) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_busy_cycles"}, nb, 4);
    chk({tag, "_busy_with_done"}, {31'd0, busy8}, 32'd0);
    pop8_chk({tag, "_result"});
    @(negedge clk);
    chk({tag, "_done_single"}, {31'd0, done8}, 32'd0);
  endtask

  initial begin
    logic [7:0] ta[3], tb[3];
    logic       tc[3];
    logic [8:0] last_res;
    int n, extra;
    ta = '{8'hC3, 8'h7F, 8'h01};
    tb = '{8'h5E, 8'h80, 8'hFF};
    tc = '{1'b1, 1'b1, 1'b0};

    @(negedge clk);
    chk("reset_busy", {31'd0, busy8}, 32'd0);
    chk("reset_done", {31'd0, done8}, 32'd0);
    chk("reset_sum_cout", {23'd0, cout8, sum8}, 32'd0);
    rst = 1'b0;

    add8("t1", 8'h5A, 8'h3C, 1'b0);
    add8("t2a", 8'hFF, 8'h01, 1'b0);
    add8("t2b", 8'hFF, 8'hFF, 1'b1);

    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h030);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_done", {31'd0, done8}, 32'd1);
    pop8_chk("t3_result");
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8) extra++;
    end
    chk("t3_extra_done", extra, 0);

    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    chk("t4_busy_before", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t4_busy", {31'd0, busy8}, 32'd0);
    chk("t4_done", {31'd0, done8}, 32'd0);
    chk("t4_sum_cout", {23'd0, cout8, sum8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    chk("t4_no_activity", extra, 0);

    last_res = 9'h000;
    @(negedge clk);
    a8 = ta[0]; b8 = tb[0]; cin8 = tc[0]; start8 = 1'b1;
    q8.push_back(9'(ta[0]) + 9'(tb[0]) + 9'(tc[0]));
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!done8) chk("t5_hold", {23'd0, cout8, sum8}, {23'd0, last_res});
      end while (!done8 && n < 20);
      chk("t5_period", n, 5);
      last_res = {cout8, sum8};
      pop8_chk("t5_result");
      if (k < 2) begin
        a8 = ta[k+1]; b8 = tb[k+1]; cin8 = tc[k+1];
        q8.push_back(9'(ta[k+1]) + 9'(tb[k+1]) + 9'(tc[k+1]));
      end else start8 = 1'b0;
    end
    @(negedge clk);
    chk("t5_done_end", {31'd0, done8}, 32'd0);

    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(ic); start2 = 1'b1;
          q2.push_back(3'(ia + ib + ic));
          @(negedge clk);
          start2 = 1'b0;
          chk("t6_busy", {30'd0, busy2, done2}, 32'd2);
          @(negedge clk);
          chk("t6_done", {30'd0, busy2, done2}, 32'd1);
          chk("t6_sb_pending", 32'(q2.size() > 0), 32'd1);
          if (q2.size() > 0) chk("t6_result", {29'd0, cout2, sum2}, {29'd0, q2.pop_front()});
        end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
